lsu: RTL and testbench
======================

# lsu

Memory-access stage of the in-order core, sitting directly downstream of the execute unit. It is the receiving end of the execute→memory valid/ready handshake: it accepts one instruction at a time, performs the load or store on a single-outstanding memory bus, and presents the result to the write-back stage through a second valid/ready handshake. Non-memory instructions pass through with one cycle of latency.

## Interface
- XLEN, 32: data/address width
- clock  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high
- e_valid_i  input  1  execute stage holds a valid instruction
- m_ready_o  output  1  lsu can accept an instruction this cycle
- res_i  input  XLEN  ALU result; byte address for load/store
- src2_i  input  XLEN  store data, LSB-aligned
- is_load_i  input  1  instruction is a load
- is_store_i  input  1  instruction is a store
- funct3_i  input  3  size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
- m_valid_o  output  1  result valid to write-back
- W_ready_i  input  1  write-back accepts result
- res_o  output  XLEN  load data (extended) or passed-through res_i
- misalign_o  output  1  qualifies m_valid_o: access was misaligned
- mem_req_valid_o  output  1  bus request valid
- mem_req_ready_i  input  1  bus accepts request
- mem_addr_o  output  XLEN  word-aligned address ({res_i[XLEN-1:2],2'b00})
- mem_wen_o  output  1  1 = write
- mem_wdata_o  output  XLEN  store data shifted to byte lane
- mem_wmask_o  output  4  byte-enable mask
- mem_rsp_valid_i  input  1  response/ack; one per accepted request
- mem_rdata_i  input  XLEN  read word

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: m_ready_o=1. Accept on e_valid_i & m_ready_o; latch res_i, src2_i, is_load_i, is_store_i, funct3_i.
  - neither load nor store → DONE, res_o = latched res_i.
  - load/store aligned → REQ.
  - misaligned (half with addr[0]=1, word with addr[1:0]≠0) → DONE, misalign_o=1, res_o=0, no bus request.
- REQ: mem_req_valid_o=1, address/wen/wdata/wmask stable until mem_req_ready_i; on handshake → WAIT.
- WAIT: on mem_rsp_valid_i → DONE; for loads capture rdata lane, shift right by 8*addr[1:0], sign/zero-extend per funct3; stores give res_o=0.
- DONE: m_valid_o=1, res_o/misalign_o held stable until W_ready_i; then → IDLE.
- Masks: byte 0001<<a, half 0011<<a, word 1111; wdata = src2_i << 8*a (a = addr[1:0]).
- m_ready_o is high only in IDLE; no accept in DONE even if W_ready_i is high (one bubble per instruction).
- mem_rsp_valid_i outside WAIT is ignored.

## Timing
- Reset: state IDLE, m_ready_o=1, m_valid_o=0, misalign_o=0, res_o=0, mem_req_valid_o=0, mem_wen_o=0, mem_addr_o=0, mem_wdata_o=0, mem_wmask_o=0.
- Reset mid-transaction (REQ/WAIT/DONE) returns to IDLE next edge; pending result discarded; a late response is ignored.
- Non-memory op accepted at edge N: m_valid_o high after edge N+1 (one cycle).
- Memory op accepted at N: mem_req_valid_o after N+1; if ready same cycle, WAIT after N+2; response at cycle k → m_valid_o after k+1. Minimum load-to-use through lsu: 3 cycles.
- mem_req_ready_i and mem_rsp_valid_i in the same cycle in REQ: the response is not accepted there; memory must return rsp at least one cycle after request handshake.
- Stall: W_ready_i low holds DONE indefinitely, all outputs constant.

## Test plan
- ALU passthrough: res_i=0x1234_5678, no load/store, W_ready_i=1 → m_valid_o one cycle later, res_o=0x1234_5678, no bus request.
- lb sign-extend: addr 0x8000_0003, rdata 0x80AA_BBCC → mem_addr_o=0x8000_0000, res_o=0xFFFF_FF80; lbu → 0x0000_0080.
- sh: addr 0x102, src2_i=0xDEAD_BEEF → wmask=1100, wdata=0xBEEF_0000, wen=1; res_o=0 after ack.
- Misaligned lw addr 0x101 → no mem_req_valid_o, m_valid_o next cycle with misalign_o=1, res_o=0.
- Backpressure: mem_req_ready_i low 3 cycles, then W_ready_i low 2 cycles → request/result held stable, m_ready_o=0 throughout, exactly one transfer each side.
- Reset asserted in WAIT, response arrives after reset → stays IDLE, m_valid_o never asserts, next instruction accepted normally.

Source files
------------

// File: rtl/lsu.sv
// lsu: memory-access stage with single-outstanding bus and valid/ready handshakes on both sides
module lsu #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            e_valid_i,
    output logic            m_ready_o,
    input  logic [XLEN-1:0] res_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            is_load_i,
    input  logic            is_store_i,
    input  logic [2:0]      funct3_i,
    output logic            m_valid_o,
    input  logic            W_ready_i,
    output logic [XLEN-1:0] res_o,
    output logic            misalign_o,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_addr_o,
    output logic            mem_wen_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [3:0]      mem_wmask_o,
    input  logic            mem_rsp_valid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t r_state, w_next;
    logic [XLEN-1:0] r_addr, r_wd, r_res;
    logic            r_load, r_store, r_mis;
    logic [2:0]      r_f3;
    logic            w_acc, w_mem, w_mis_in, w_req;
    logic [XLEN-1:0] w_sh, w_ld;
    assign w_acc    = (r_state == IDLE) && e_valid_i;
    assign w_mem    = is_load_i | is_store_i;
    assign w_mis_in = w_mem && (funct3_i[1] ? (res_i[1:0] != 2'b00) : (funct3_i[0] & res_i[0]));
    assign w_req    = (r_state == REQ);
    assign w_sh     = mem_rdata_i >> {r_addr[1:0], 3'b000};
    assign w_ld     = r_f3[1] ? w_sh :
                      r_f3[0] ? {{(XLEN-16){~r_f3[2] & w_sh[15]}}, w_sh[15:0]} :
                                {{(XLEN-8){~r_f3[2] & w_sh[7]}}, w_sh[7:0]};
    assign m_ready_o       = (r_state == IDLE);
    assign m_valid_o       = (r_state == DONE);
    assign res_o           = r_res;
    assign misalign_o      = r_mis;
    assign mem_req_valid_o = w_req;
    assign mem_addr_o      = w_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
    assign mem_wen_o       = w_req & r_store;
    assign mem_wdata_o     = w_req ? r_wd << {r_addr[1:0], 3'b000} : '0;
    assign mem_wmask_o     = !w_req ? 4'b0000 :
                             r_f3[1] ? 4'b1111 :
                             r_f3[0] ? 4'b0011 << r_addr[1:0] : 4'b0001 << r_addr[1:0];
    // state register
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    // next-state: aligned memory ops go to the bus, everything else straight to DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (e_valid_i) w_next = (w_mem && !w_mis_in) ? REQ : DONE;
            REQ:     if (mem_req_ready_i) w_next = WAIT;
            WAIT:    if (mem_rsp_valid_i) w_next = DONE;
            default: if (W_ready_i) w_next = IDLE;
        endcase
    end
    // latch the instruction on accept and capture the result once it is known
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr  <= '0;
            r_wd    <= '0;
            r_load  <= 1'b0;
            r_store <= 1'b0;
            r_f3    <= 3'b000;
            r_res   <= '0;
            r_mis   <= 1'b0;
        end else if (w_acc) begin
            r_addr  <= res_i;
            r_wd    <= src2_i;
            r_load  <= is_load_i;
            r_store <= is_store_i;
            r_f3    <= funct3_i;
            r_res   <= w_mem ? '0 : res_i;
            r_mis   <= w_mis_in;
        end else if (r_state == WAIT && mem_rsp_valid_i) begin
            r_res   <= r_load ? w_ld : '0;
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: table-driven scoreboard bench for the lsu memory-access stage
module tb_lsu;
    logic        clock = 0, reset = 1;
    logic        e_valid_i = 0, is_load_i = 0, is_store_i = 0;
    logic [31:0] res_i = 0, src2_i = 0, mem_rdata_i = 0;
    logic [2:0]  funct3_i = 0;
    logic        W_ready_i = 0, mem_req_ready_i = 0, mem_rsp_valid_i = 0;
    logic        m_ready_o, m_valid_o, misalign_o, mem_req_valid_o, mem_wen_o;
    logic [31:0] res_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    int checks = 0, errors = 0, req_cnt = 0, wb_cnt = 0;

    typedef struct {
        logic [31:0] addr, src2;
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] rdata, exp_res;
        logic        exp_mis, exp_req, exp_wen;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wmask;
    } vec_t;
    typedef struct {
        logic [31:0] res;
        logic        mis;
    } exp_t;
    vec_t tbl[12];
    exp_t sb[$];

    lsu dut (
        .clock(clock), .reset(reset), .e_valid_i(e_valid_i), .m_ready_o(m_ready_o),
        .res_i(res_i), .src2_i(src2_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
        .funct3_i(funct3_i), .m_valid_o(m_valid_o), .W_ready_i(W_ready_i), .res_o(res_o),
        .misalign_o(misalign_o), .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o),
        .mem_wmask_o(mem_wmask_o), .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clock = ~clock;

    // count transfers on each side of the stage
    always @(posedge clock) begin
        if (mem_req_valid_o && mem_req_ready_i) req_cnt++;
        if (m_valid_o && W_ready_i) wb_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input vec_t v);
        chk({tag, "_addr"}, mem_addr_o, {v.addr[31:2], 2'b00});
        chk({tag, "_wen"}, {31'd0, mem_wen_o}, {31'd0, v.exp_wen});
        chk({tag, "_wdata"}, mem_wdata_o, v.exp_wdata);
        chk({tag, "_wmask"}, {28'd0, mem_wmask_o}, {28'd0, v.exp_wmask});
    endtask

    task automatic do_op(input vec_t v, input int rs, input int ws);
        int n, rq0, wb0;
        exp_t e;
        rq0 = req_cnt;
        wb0 = wb_cnt;
        res_i = v.addr; src2_i = v.src2; is_load_i = v.ld; is_store_i = v.st; funct3_i = v.f3;
        e_valid_i = 1;
        #1 chk("m_ready_idle", {31'd0, m_ready_o}, 32'd1);
        sb.push_back('{v.exp_res, v.exp_mis});
        @(posedge clock); #1;
        e_valid_i = 0; is_load_i = 0; is_store_i = 0; res_i = $urandom; src2_i = $urandom;
        #1;
        if (v.exp_req) begin
            n = 0;
            while (!mem_req_valid_o && n < 20) begin @(posedge clock); #2; n++; end
            chk("req_valid", {31'd0, mem_req_valid_o}, 32'd1);
            for (int i = 0; i < rs; i++) begin
                chk("stall_m_ready", {31'd0, m_ready_o}, 32'd0);
                chk_bus("stall", v);
                mem_rsp_valid_i = 1;
                @(posedge clock); #1;
                mem_rsp_valid_i = 0;
                #1;
            end
            chk("stall_no_valid", {31'd0, m_valid_o}, 32'd0);
            chk_bus("req", v);
            mem_req_ready_i = 1;
            @(posedge clock); #1;
            mem_req_ready_i = 0; mem_rsp_valid_i = 1; mem_rdata_i = v.rdata;
            @(posedge clock); #1;
            mem_rsp_valid_i = 0; mem_rdata_i = $urandom;
            #1;
        end else begin
            chk("no_req", {31'd0, mem_req_valid_o}, 32'd0);
            if (!v.ld && !v.st) chk("pass_latency", {31'd0, m_valid_o}, 32'd1);
        end
        n = 0;
        while (!m_valid_o && n < 20) begin @(posedge clock); #2; n++; end
        chk("m_valid", {31'd0, m_valid_o}, 32'd1);
        for (int i = 0; i < ws; i++) begin
            chk("wb_stall_m_ready", {31'd0, m_ready_o}, 32'd0);
            chk("wb_stall_res", res_o, v.exp_res);
            @(posedge clock); #2;
            chk("wb_stall_valid", {31'd0, m_valid_o}, 32'd1);
        end
        W_ready_i = 1;
        #1;
        if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
        else begin
            e = sb.pop_front();
            chk("res", res_o, e.res);
            chk("misalign", {31'd0, misalign_o}, {31'd0, e.mis});
        end
        @(posedge clock); #1;
        W_ready_i = 0;
        #1;
        chk("back_idle", {31'd0, m_ready_o}, 32'd1);
        chk("req_xfers", req_cnt - rq0, v.exp_req ? 32'd1 : 32'd0);
        chk("wb_xfers", wb_cnt - wb0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{32'h1234_5678, 0, 0, 0, 3'b000, 0, 32'h1234_5678, 0, 0, 0, 0, 4'h0};
        tbl[1]  = '{32'h8000_0003, 0, 1, 0, 3'b000, 32'h80AA_BBCC, 32'hFFFF_FF80, 0, 1, 0, 0, 4'h8};
        tbl[2]  = '{32'h8000_0003, 0, 1, 0, 3'b100, 32'h80AA_BBCC, 32'h0000_0080, 0, 1, 0, 0, 4'h8};
        tbl[3]  = '{32'h0000_0102, 32'hDEAD_BEEF, 0, 1, 3'b001, 0, 0, 0, 1, 1, 32'hBEEF_0000, 4'hC};
        tbl[4]  = '{32'h0000_0101, 0, 1, 0, 3'b010, 0, 0, 1, 0, 0, 0, 4'h0};
        tbl[5]  = '{32'h0000_0200, 0, 1, 0, 3'b010, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 1, 0, 0, 4'hF};
        tbl[6]  = '{32'h0000_0202, 0, 1, 0, 3'b001, 32'h8001_1234, 32'hFFFF_8001, 0, 1, 0, 0, 4'hC};
        tbl[7]  = '{32'h0000_0200, 0, 1, 0, 3'b101, 32'h8001_F234, 32'h0000_F234, 0, 1, 0, 0, 4'h3};
        tbl[8]  = '{32'h0000_0301, 32'h0000_00A5, 0, 1, 3'b000, 0, 0, 0, 1, 1, 32'h0000_A500, 4'h2};
        tbl[9]  = '{32'h0000_0303, 0, 0, 1, 3'b001, 0, 0, 1, 0, 0, 0, 4'h0};
        tbl[10] = '{32'h0000_0400, 32'h1122_3344, 0, 1, 3'b010, 0, 0, 0, 1, 1, 32'h1122_3344, 4'hF};
        tbl[11] = '{32'h0000_0001, 0, 1, 0, 3'b000, 32'h0000_7F00, 32'h0000_007F, 0, 1, 0, 0, 4'h2};
        repeat (2) @(posedge clock);
        #1 reset = 0;
        #1;
        chk("rst_m_ready", {31'd0, m_ready_o}, 32'd1);
        chk("rst_m_valid", {31'd0, m_valid_o}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
        chk("rst_res", res_o, 32'd0);
        chk("rst_req", {31'd0, mem_req_valid_o}, 32'd0);
        chk("rst_wen", {31'd0, mem_wen_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_wmask", {28'd0, mem_wmask_o}, 32'd0);
        for (int i = 0; i < 12; i++) do_op(tbl[i], 0, 0);
        do_op(tbl[5], 3, 2);
        do_op(tbl[3], 2, 1);
        res_i = 32'h0000_0500; is_load_i = 1; funct3_i = 3'b010; e_valid_i = 1;
        @(posedge clock); #1;
        e_valid_i = 0; is_load_i = 0; mem_req_ready_i = 1;
        @(posedge clock); #1;
        mem_req_ready_i = 0; reset = 1;
        @(posedge clock); #1;
        reset = 0; mem_rsp_valid_i = 1; mem_rdata_i = 32'h5555_AAAA;
        #1 chk("rstw_m_ready", {31'd0, m_ready_o}, 32'd1);
        @(posedge clock); #1;
        mem_rsp_valid_i = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rstw_no_valid", {31'd0, m_valid_o}, 32'd0);
            chk("rstw_idle", {31'd0, m_ready_o}, 32'd1);
            @(posedge clock); #1;
        end
        do_op(tbl[1], 0, 0);
        do_op(tbl[0], 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
